// File: rtl/axi_mem_slave.sv
// AXI4 slave memory model: 64-bit byte-strobed RAM with independent read and write burst FSMs.
// Start address decides the SLVERR range check; the burst then walks the array modulo depth.
module axi_mem_slave #(
   parameter int unsigned MEM_WORDS_LOG2 = 12,
   parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_8000_0000,
   parameter int unsigned ID_WIDTH       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   // write address
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_WIDTH-1:0] awid,
   input  logic [63:0]         awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   // write data
   input  logic                wvalid,
   output logic                wready,
   input  logic [63:0]         wdata,
   input  logic [7:0]          wstrb,
   input  logic                wlast,
   // write response
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_WIDTH-1:0] bid,
   output logic [1:0]          bresp,
   // read address
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_WIDTH-1:0] arid,
   input  logic [63:0]         araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   // read data
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_WIDTH-1:0] rid,
   output logic [63:0]         rdata,
   output logic [1:0]          rresp,
   output logic                rlast
);

   localparam int unsigned Depth    = 2 ** MEM_WORDS_LOG2;
   localparam logic [63:0] MemBytes = 64'(Depth) << 3;
   localparam logic [1:0]  RespOkay = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   typedef logic [MEM_WORDS_LOG2-1:0] idx_t;
   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic [0:0] {RIdle, RData} r_state_e;

   logic [63:0] mem_q [Depth];

   // Beat size is always 8 bytes, so the size fields carry no information.
   logic unused_size;
   assign unused_size = ^{awsize, arsize};

   // Address decode: offset from base gives both the index and the range check.
   logic [63:0] aw_off, ar_off;
   logic        aw_oor, ar_oor;
   idx_t        aw_idx, ar_idx;

   assign aw_off = awaddr - BASE_ADDR;
   assign ar_off = araddr - BASE_ADDR;
   assign aw_oor = (awaddr < BASE_ADDR) || (aw_off >= MemBytes);
   assign ar_oor = (araddr < BASE_ADDR) || (ar_off >= MemBytes);
   assign aw_idx = aw_off[MEM_WORDS_LOG2+2:3];
   assign ar_idx = ar_off[MEM_WORDS_LOG2+2:3];

   // ---------------------------------------------------------------- write channel
   w_state_e            w_state_q, w_state_d;
   logic [ID_WIDTH-1:0] w_id_q, w_id_d;
   idx_t                w_idx_q, w_idx_d;
   logic [7:0]          w_len_q, w_len_d;
   logic [7:0]          w_cnt_q, w_cnt_d;
   logic                w_fixed_q, w_fixed_d;
   logic                w_oor_q, w_oor_d;
   logic                w_err_q, w_err_d;
   logic                w_beat_last;
   logic                mem_we;

   assign w_beat_last = (w_cnt_q == w_len_q);
   assign mem_we      = (w_state_q == WData) && wvalid && !w_oor_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= WIdle;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_fixed_q <= 1'b0;
         w_oor_q   <= 1'b0;
         w_err_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_fixed_q <= w_fixed_d;
         w_oor_q   <= w_oor_d;
         w_err_q   <= w_err_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_fixed_d = w_fixed_q;
      w_oor_d   = w_oor_q;
      w_err_d   = w_err_q;
      unique case (w_state_q)
         WIdle: begin
            if (awvalid) begin
               w_state_d = WData;
               w_id_d    = awid;
               w_idx_d   = aw_idx;
               w_len_d   = awlen;
               w_cnt_d   = '0;
               w_fixed_d = (awburst == 2'b00);
               w_oor_d   = aw_oor;
               // WRAP and reserved types run as INCR but are flagged.
               w_err_d   = aw_oor | awburst[1];
            end
         end
         WData: begin
            if (wvalid) begin
               if (wlast != w_beat_last) w_err_d = 1'b1;
               w_cnt_d = w_cnt_q + 8'd1;
               if (!w_fixed_q) w_idx_d = w_idx_q + idx_t'(1);
               if (w_beat_last) w_state_d = WResp;
            end
         end
         WResp: begin
            if (bready) w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      awready = (w_state_q == WIdle);
      wready  = (w_state_q == WData);
      bvalid  = (w_state_q == WResp);
      bid     = w_id_q;
      bresp   = w_err_q ? RespSlvErr : RespOkay;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // ---------------------------------------------------------------- read channel
   r_state_e            r_state_q, r_state_d;
   logic [ID_WIDTH-1:0] r_id_q, r_id_d;
   idx_t                r_idx_q, r_idx_d;
   logic [7:0]          r_len_q, r_len_d;
   logic [7:0]          r_cnt_q, r_cnt_d;
   logic                r_fixed_q, r_fixed_d;
   logic                r_oor_q, r_oor_d;
   logic                r_err_q, r_err_d;
   logic [63:0]         rdata_q, rdata_d;
   logic                r_beat_last;
   idx_t                r_idx_nxt, rd_idx;
   logic [63:0]         rd_word;

   assign r_beat_last = (r_cnt_q == r_len_q);
   assign r_idx_nxt   = r_fixed_q ? r_idx_q : r_idx_q + idx_t'(1);
   assign rd_idx      = (r_state_q == RIdle) ? ar_idx : r_idx_nxt;
   // Sampled before this edge's write lands, so a same-word collision sees the old data.
   assign rd_word     = mem_q[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= RIdle;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_fixed_q <= 1'b0;
         r_oor_q   <= 1'b0;
         r_err_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_fixed_q <= r_fixed_d;
         r_oor_q   <= r_oor_d;
         r_err_q   <= r_err_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_fixed_d = r_fixed_q;
      r_oor_d   = r_oor_q;
      r_err_d   = r_err_q;
      rdata_d   = rdata_q;
      unique case (r_state_q)
         RIdle: begin
            if (arvalid) begin
               r_state_d = RData;
               r_id_d    = arid;
               r_idx_d   = ar_idx;
               r_len_d   = arlen;
               r_cnt_d   = '0;
               r_fixed_d = (arburst == 2'b00);
               r_oor_d   = ar_oor;
               r_err_d   = ar_oor | arburst[1];
               rdata_d   = ar_oor ? '0 : rd_word;
            end
         end
         RData: begin
            if (rready) begin
               if (r_beat_last) begin
                  r_state_d = RIdle;
               end else begin
                  r_cnt_d = r_cnt_q + 8'd1;
                  r_idx_d = r_idx_nxt;
                  rdata_d = r_oor_q ? '0 : rd_word;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_comb begin
      arready = (r_state_q == RIdle);
      rvalid  = (r_state_q == RData);
      rlast   = rvalid & r_beat_last;
      rid     = r_id_q;
      rdata   = rdata_q;
      rresp   = r_err_q ? RespSlvErr : RespOkay;
   end

endmodule
